// File: rtl/bitmap_blitter.sv
// bitmap_blitter: renders a ROWS x COLS one-bit bitmap as pixel blocks
// on the 160x120 VGA adapter. Optional macro BLIT_CLIP_EN clips off-screen.
module bitmap_blitter #(
  parameter int COLS    = 16,
  parameter int ROWS    = 16,
  parameter int CELL_W  = 2,
  parameter int CELL_H  = 2,
  parameter int PITCH_X = 10,
  parameter int PITCH_Y = 7,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic            fastclock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            start,
  input  logic [7:0]      origin_x,
  input  logic [6:0]      origin_y,
  input  logic [2:0]      fg,
  input  logic [2:0]      bg,
  input  logic            transparent,
  output logic [7:0]      x,
  output logic [6:0]      y,
  output logic [2:0]      colour,
  output logic            plot,
  output logic            busy,
  output logic            done
);

`ifdef BLIT_CLIP_EN
  localparam int XW = 9;
  localparam int YW = 8;
`else
  localparam int XW = 8;
  localparam int YW = 7;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAW, S_NEXT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [COLS-1:0] mem_q [ROWS];
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [2:0]      px_q, px_d;
  logic [2:0]      py_q, py_d;
  logic [7:0]      ox_q, ox_d;
  logic [6:0]      oy_q, oy_d;
  logic [2:0]      fg_q, fg_d;
  logic [2:0]      bg_q, bg_d;
  logic            tr_q, tr_d;
  logic [2:0]      cc_q, cc_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [2:0]      col_o_q, col_o_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [COLS-1:0] cur_row;
  logic            cur_bit;
  logic            px_last;
  logic            py_last;
  logic            last_cell;
  logic [XW-1:0]   xs;
  logic [YW-1:0]   ys;

  assign cur_row   = mem_q[row_q];
  assign cur_bit   = cur_row[CW'(COLS-1) - col_q];
  assign px_last   = (px_q == 3'(CELL_W-1));
  assign py_last   = (py_q == 3'(CELL_H-1));
  assign last_cell = (row_q == RW'(ROWS-1)) &&
                     (col_q == CW'(COLS-1));
  assign xs = XW'(ox_q) + XW'(col_q * PITCH_X) + XW'(px_q);
  assign ys = YW'(oy_q) + YW'(row_q * PITCH_Y) + YW'(py_q);

  // bitmap storage; writes accepted in every state
  always_ff @(posedge fastclock) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_row] <= wr_data;
    end
  end

  // state register
  always_ff @(posedge fastclock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = (!cur_bit && tr_q) ? S_NEXT : S_DRAW;
      S_DRAW:  if (px_last && py_last) state_d = S_NEXT;
      S_NEXT:  state_d = last_cell ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // counters, latched settings and next output values
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    px_d    = px_q;
    py_d    = py_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    tr_d    = tr_q;
    cc_d    = cc_q;
    x_d     = x_q;
    y_d     = y_q;
    col_o_d = col_o_q;
    plot_d  = 1'b0;
    busy_d  = (state_q == S_FETCH) || (state_q == S_DRAW) ||
              (state_q == S_NEXT);
    done_d  = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ox_d  = origin_x;
          oy_d  = origin_y;
          fg_d  = fg;
          bg_d  = bg;
          tr_d  = transparent;
          col_d = '0;
          row_d = '0;
        end
      end
      S_FETCH: begin
        cc_d = cur_bit ? fg_q : bg_q;
        px_d = '0;
        py_d = '0;
      end
      S_DRAW: begin
        x_d     = xs[7:0];
        y_d     = ys[6:0];
        col_o_d = cc_q;
`ifdef BLIT_CLIP_EN
        plot_d  = (xs < XW'(160)) && (ys < YW'(120));
`else
        plot_d  = 1'b1;
`endif
        if (px_last) begin
          px_d = '0;
          py_d = py_q + 3'd1;
        end else begin
          px_d = px_q + 3'd1;
        end
      end
      S_NEXT: begin
        if (col_q == CW'(COLS-1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // datapath and registered adapter outputs
  always_ff @(posedge fastclock) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      tr_q    <= 1'b0;
      cc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_o_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      px_q    <= px_d;
      py_q    <= py_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      tr_q    <= tr_d;
      cc_q    <= cc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_o_q <= col_o_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = col_o_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bitmap_blitter.sv
// tb_bitmap_blitter: scoreboard bench for bitmap_blitter at default sizes.
// Expected pixels are queued from a bitmap model and popped on each plot.
module tb_bitmap_blitter;

  logic        fastclock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_row;
  logic [15:0] wr_data;
  logic        start;
  logic [7:0]  origin_x;
  logic [6:0]  origin_y;
  logic [2:0]  fg;
  logic [2:0]  bg;
  logic        transparent;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  always #5 fastclock = ~fastclock;

  bitmap_blitter dut (
    .fastclock(fastclock),
    .reset(reset),
    .wr_en(wr_en),
    .wr_row(wr_row),
    .wr_data(wr_data),
    .start(start),
    .origin_x(origin_x),
    .origin_y(origin_y),
    .fg(fg),
    .bg(bg),
    .transparent(transparent),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .busy(busy),
    .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] model [16];
  logic [17:0] sb_q [$];
  bit          sb_en = 1'b0;
  int          done_cnt = 0;

  // plot monitor: every plotted pixel must match the head of the queue
  always @(negedge fastclock) begin
    logic [17:0] e;
    if (done) done_cnt++;
    if (sb_en && plot) begin
      if (sb_q.size() == 0) begin
        check("plot_when_empty", {31'd0, plot}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("pixel", {14'd0, x, y, colour}, {14'd0, e});
      end
    end
  end

  // fills the queue from the model; returns busy cycles and first-plot lag
  task automatic build(input logic [7:0] ox, input logic [6:0] oy,
                       input logic [2:0] f, input logic [2:0] b,
                       input logic t, output int n, output int lat);
    int xx, yy;
    logic [15:0] rowv;
    logic bv, ok;
    logic [7:0] xb;
    logic [6:0] yb;
    n = 0;
    lat = -1;
    sb_q.delete();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        rowv = model[r];
        bv = rowv[15-c];
        if (!bv && t) begin
          n += 2;
        end else begin
          for (int py = 0; py < 2; py++) begin
            for (int px = 0; px < 2; px++) begin
              xx = int'(ox) + c * 10 + px;
              yy = int'(oy) + r * 7 + py;
              ok = 1'b1;
`ifdef BLIT_CLIP_EN
              ok = (xx < 160) && (yy < 120);
`endif
              if (ok) begin
                if (lat < 0) lat = n + 2 + py * 2 + px;
                xb = xx[7:0];
                yb = yy[6:0];
                sb_q.push_back({xb, yb, bv ? f : b});
              end
            end
          end
          n += 6;
        end
      end
    end
  endtask

  task automatic load_row(input int r, input logic [15:0] d);
    @(negedge fastclock);
    wr_en = 1'b1;
    wr_row = 4'(r);
    wr_data = d;
    @(negedge fastclock);
    wr_en = 1'b0;
    model[r] = d;
  endtask

  task automatic run_pass(input logic [7:0] ox, input logic [6:0] oy,
                          input logic [2:0] f, input logic [2:0] b,
                          input logic t, input int poke_at,
                          input int wr_at, input int wr_r,
                          input logic [15:0] wr_d);
    int n, elat, j, busy_n, lat, d0;
    bit seen, prev_busy;
    if (wr_at >= 0) model[wr_r] = wr_d;
    build(ox, oy, f, b, t, n, elat);
    @(negedge fastclock);
    origin_x = ox;
    origin_y = oy;
    fg = f;
    bg = b;
    transparent = t;
    start = 1'b1;
    d0 = done_cnt;
    j = 0;
    busy_n = 0;
    lat = -1;
    seen = 1'b0;
    prev_busy = 1'b0;
    while (!seen && j < 20000) begin
      @(negedge fastclock);
      j++;
      start = 1'b0;
      wr_en = 1'b0;
      if (j == poke_at) begin
        check("busy_at_poke", {31'd0, busy}, 32'd1);
        start = 1'b1;
        origin_x = 8'd77;
        fg = ~f;
        transparent = ~t;
      end
      if (j == wr_at) begin
        wr_en = 1'b1;
        wr_row = 4'(wr_r);
        wr_data = wr_d;
      end
      if (plot && lat < 0) lat = j - 1;
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        check("busy_with_done", {31'd0, busy}, 32'd0);
        check("busy_before_done", {31'd0, prev_busy}, 32'd1);
      end
      prev_busy = busy;
    end
    start = 1'b0;
    wr_en = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    check("busy_cycles", busy_n, n);
    check("first_plot_lat", lat, elat);
    repeat (4) @(negedge fastclock);
    check("done_pulses", done_cnt - d0, 32'd1);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_row = '0;
    wr_data = '0;
    start = 1'b0;
    origin_x = '0;
    origin_y = '0;
    fg = '0;
    bg = '0;
    transparent = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (3) @(negedge fastclock);
    check("rst_x", {24'd0, x}, 32'd0);
    check("rst_y", {25'd0, y}, 32'd0);
    check("rst_colour", {29'd0, colour}, 32'd0);
    check("rst_plot", {31'd0, plot}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    sb_en = 1'b1;

    run_pass(8'd0, 7'd0, 3'b000, 3'b001, 1'b0, -1, -1, 0, 16'h0);

    load_row(0, 16'h8000);
    run_pass(8'd0, 7'd0, 3'b110, 3'b000, 1'b1, -1, -1, 0, 16'h0);

    load_row(0, 16'h0000);
    load_row(15, 16'h0001);
    run_pass(8'd5, 7'd3, 3'b011, 3'b000, 1'b1, -1, -1, 0, 16'h0);
    run_pass(8'd10, 7'd20, 3'b100, 3'b000, 1'b1, -1, -1, 0, 16'h0);

    for (int i = 0; i < 16; i++) load_row(i, 16'($urandom));
    run_pass(8'd30, 7'd10, 3'b010, 3'b100, 1'b1, 50, -1, 0, 16'h0);
    run_pass(8'd200, 7'd100, 3'b111, 3'b001, 1'b0, -1, 130, 2, 16'hA5C3);

    sb_en = 1'b0;
    @(negedge fastclock);
    origin_x = 8'd0;
    origin_y = 7'd0;
    fg = 3'b010;
    bg = 3'b011;
    transparent = 1'b0;
    start = 1'b1;
    repeat (303) begin
      @(negedge fastclock);
      start = 1'b0;
    end
    check("plot_before_reset", {31'd0, plot}, 32'd1);
    reset = 1'b1;
    @(negedge fastclock);
    check("abort_plot", {31'd0, plot}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_x", {24'd0, x}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge fastclock);
    check("after_abort_plot", {31'd0, plot}, 32'd0);
    check("after_abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    sb_en = 1'b1;
    run_pass(8'd0, 7'd0, 3'b110, 3'b101, 1'b0, -1, -1, 0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
